// File: rtl/gb_io_pkg.sv
// gb_io_pkg: shared DMG I/O constants for the timer block and its address decode.
package gb_io_pkg;

    localparam logic [15:0] ADDR_DIV  = 16'hFF04;
    localparam logic [15:0] ADDR_TIMA = 16'hFF05;
    localparam logic [15:0] ADDR_TMA  = 16'hFF06;
    localparam logic [15:0] ADDR_TAC  = 16'hFF07;

    typedef enum logic [1:0] {
        TAC_1024 = 2'b00,
        TAC_16   = 2'b01,
        TAC_64   = 2'b10,
        TAC_256  = 2'b11
    } tac_sel_t;

    localparam logic [4:0] TAC_UNUSED_BITS = 5'b11111;

endpackage

// File: rtl/gb_timer.sv
// gb_timer: DMG DIV/TIMA/TMA/TAC timer with falling-edge TIMA clocking and delayed TMA reload.
module gb_timer
    import gb_io_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = ADDR_DIV
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wren,
    input  logic [7:0]  cpu_data_in,
    output logic        hit,
    output logic [7:0]  data_out,
    output logic        timer_int
);

    localparam logic [1:0] OFF_DIV  = 2'(ADDR_DIV  - ADDR_DIV);
    localparam logic [1:0] OFF_TIMA = 2'(ADDR_TIMA - ADDR_DIV);
    localparam logic [1:0] OFF_TMA  = 2'(ADDR_TMA  - ADDR_DIV);
    localparam logic [1:0] OFF_TAC  = 2'(ADDR_TAC  - ADDR_DIV);

    logic [15:0] div_q, div_d;
    logic [7:0]  tima_q, tima_d;
    logic [7:0]  tma_q, tma_d;
    logic [2:0]  tac_q, tac_d;
    logic        reload_q, reload_d;
    logic        tap_q, tap_d;
    logic        int_q, int_d;

    logic [15:0] off;
    logic        wr_div, wr_tima, wr_tma, wr_tac, tima_wr, fall, tap_bit;
    tac_sel_t    sel;

    // The tap is evaluated on the post-edge DIV/TAC so that DIV and TAC writes
    // produce their falling-edge increment on the same edge as the write.
    always_comb begin
        off      = cpu_addr - BASE_ADDR;
        hit      = (off[15:2] == 14'd0);
        wr_div   = cpu_wren & hit & (off[1:0] == OFF_DIV);
        wr_tima  = cpu_wren & hit & (off[1:0] == OFF_TIMA);
        wr_tma   = cpu_wren & hit & (off[1:0] == OFF_TMA);
        wr_tac   = cpu_wren & hit & (off[1:0] == OFF_TAC);
        div_d    = wr_div ? 16'd0 : div_q + 16'd1;
        tac_d    = wr_tac ? cpu_data_in[2:0] : tac_q;
        tma_d    = wr_tma ? cpu_data_in : tma_q;
        sel      = tac_sel_t'(tac_d[1:0]);
        tap_bit  = (sel == TAC_16)  ? div_d[3] :
                   (sel == TAC_64)  ? div_d[5] :
                   (sel == TAC_256) ? div_d[7] : div_d[9];
        tap_d    = tac_d[2] & tap_bit;
        fall     = tap_q & ~tap_d;
        tima_wr  = wr_tima & ~int_q;
        reload_d = ~reload_q & ~tima_wr & fall & (tima_q == 8'hFF);
        int_d    = reload_q & ~tima_wr;
        tima_d   = reload_q ? (tima_wr ? cpu_data_in : tma_d) :
                   tima_wr  ? cpu_data_in :
                   fall     ? tima_q + 8'd1 : tima_q;
        data_out = !hit                 ? 8'hFF :
                   (off[1:0] == OFF_DIV)  ? div_q[15:8] :
                   (off[1:0] == OFF_TIMA) ? tima_q :
                   (off[1:0] == OFF_TMA)  ? tma_q : {TAC_UNUSED_BITS, tac_q};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_q    <= '0;
            tima_q   <= '0;
            tma_q    <= '0;
            tac_q    <= '0;
            reload_q <= 1'b0;
            tap_q    <= 1'b0;
            int_q    <= 1'b0;
        end else begin
            div_q    <= div_d;
            tima_q   <= tima_d;
            tma_q    <= tma_d;
            tac_q    <= tac_d;
            reload_q <= reload_d;
            tap_q    <= tap_d;
            int_q    <= int_d;
        end
    end

    assign timer_int = int_q;

endmodule

// File: tb/tb_gb_timer.sv
// tb_gb_timer: directed stimulus with a cycle model of the DMG timer plus literal expectations.
module tb_gb_timer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] cpu_addr = 16'hFF04;
    logic        cpu_wren = 1'b0;
    logic [7:0]  cpu_data_in = 8'h00;
    logic        hit;
    logic [7:0]  data_out;
    logic        timer_int;

    int checks = 0;
    int failures = 0;
    int int_count = 0;

    gb_timer dut (
        .clock(clock), .reset(reset), .cpu_addr(cpu_addr), .cpu_wren(cpu_wren),
        .cpu_data_in(cpu_data_in), .hit(hit), .data_out(data_out), .timer_int(timer_int)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    int         m_div = 0;
    logic [7:0] m_tima = 0, m_tma = 0;
    logic [2:0] m_tac = 0;
    bit         m_pend = 0, m_int = 0, m_tap = 0;

    function automatic bit tapf(input int d, input logic [2:0] t);
        int half;
        half = (t[1:0] == 2'd0) ? 512 : (t[1:0] == 2'd1) ? 8 : (t[1:0] == 2'd2) ? 32 : 128;
        return t[2] && ((d / half) % 2 == 1);
    endfunction

    function automatic logic [7:0] mread(input logic [15:0] a);
        case (a)
            16'hFF04: return 8'(m_div / 256);
            16'hFF05: return m_tima;
            16'hFF06: return m_tma;
            16'hFF07: return {5'b11111, m_tac};
            default:  return 8'hFF;
        endcase
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_div = 0; m_tima = 0; m_tma = 0; m_tac = 0;
            m_pend = 0; m_int = 0; m_tap = 0;
        end else begin
            bit wr, wt, ntap, fell, nint;
            int nd;
            wr   = cpu_wren && cpu_addr >= 16'hFF04 && cpu_addr <= 16'hFF07;
            wt   = wr && cpu_addr == 16'hFF05;
            nd   = (wr && cpu_addr == 16'hFF04) ? 0 : (m_div + 1) % 65536;
            if (wr && cpu_addr == 16'hFF07) m_tac = cpu_data_in[2:0];
            if (wr && cpu_addr == 16'hFF06) m_tma = cpu_data_in;
            ntap = tapf(nd, m_tac);
            fell = m_tap && !ntap;
            nint = 0;
            if (m_pend) begin
                m_tima = wt ? cpu_data_in : m_tma;
                nint   = !wt;
                m_pend = 0;
            end else if (wt && !m_int) begin
                m_tima = cpu_data_in;
            end else if (fell) begin
                if (m_tima == 8'hFF) begin
                    m_tima = 0;
                    m_pend = 1;
                end else begin
                    m_tima = m_tima + 8'd1;
                end
            end
            m_div = nd;
            m_tap = ntap;
            m_int = nint;
        end
    end

    always @(negedge clock) begin
        chk("cyc_int", timer_int, m_int);
        chk("cyc_hit", hit, cpu_addr >= 16'hFF04 && cpu_addr <= 16'hFF07);
        chk("cyc_data", data_out, mread(cpu_addr));
        if (timer_int) int_count++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_data_in = d; cpu_wren = 1'b1;
        @(posedge clock);
        #1 cpu_wren = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] v);
        cpu_addr = a;
        #1 v = data_out;
    endtask

    initial begin
        logic [7:0] v, prev, t0;
        int ic;
        bit found;
        tick(3);
        rd(16'hFF04, v); chk("rst_div", v, 8'h00);
        rd(16'hFF07, v); chk("rst_tac", v, 8'hF8);
        chk("rst_int", timer_int, 1'b0);
        reset = 1'b1;
        tick(512);
        rd(16'hFF04, v); chk("idle_div", v, 8'h02);
        rd(16'hFF05, v); chk("idle_tima", v, 8'h00);
        rd(16'hFF07, v); chk("idle_tac", v, 8'hF8);
        chk("idle_no_int", int_count, 0);

        wr(16'hFF07, 8'h05);
        wr(16'hFF06, 8'h10);
        tick(160);
        rd(16'hFF05, v); chk("count16_tima", v, 8'h0A);
        found = 0;
        for (int i = 0; i < 5000 && !found; i++) begin
            rd(16'hFF05, prev);
            tick(1);
            if (timer_int) begin
                found = 1;
                chk("ovf_prev_zero", prev, 8'h00);
                rd(16'hFF05, v); chk("ovf_reload", v, 8'h10);
                tick(1);
                chk("ovf_pulse_one", timer_int, 1'b0);
            end
        end
        chk("ovf_seen", found, 1'b1);

        ic = int_count;
        wr(16'hFF05, 8'hFF);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            rd(16'hFF05, v);
            if (v == 8'h00) begin
                found = 1;
                wr(16'hFF05, 8'h40);
            end else begin
                tick(1);
            end
        end
        chk("cancel_seen_zero", found, 1'b1);
        rd(16'hFF05, v); chk("cancel_tima", v, 8'h40);
        tick(3);
        chk("cancel_no_int", int_count, ic);

        wr(16'hFF04, 8'h5A);
        tick(8);
        rd(16'hFF05, t0);
        wr(16'hFF04, 8'h00);
        rd(16'hFF04, v); chk("divw_div", v, 8'h00);
        rd(16'hFF05, v); chk("divw_glitch", v, t0 + 8'd1);

        tick(8);
        rd(16'hFF05, t0);
        wr(16'hFF07, 8'h01);
        rd(16'hFF05, v); chk("tacw_glitch", v, t0 + 8'd1);
        rd(16'hFF07, v); chk("tacw_tac", v, 8'hF9);
        tick(1000);
        rd(16'hFF05, v); chk("tacw_stopped", v, t0 + 8'd1);

        cpu_addr = 16'hFF08; cpu_data_in = 8'hAA; cpu_wren = 1'b1;
        #1;
        chk("oob_hit", hit, 1'b0);
        chk("oob_data", data_out, 8'hFF);
        @(posedge clock);
        #1 cpu_wren = 1'b0;
        rd(16'hFF06, v); chk("oob_tma", v, 8'h10);
        rd(16'hFF07, v); chk("oob_tac", v, 8'hF9);
        rd(16'hFF05, v); chk("oob_tima", v, t0 + 8'd1);
        cpu_addr = 16'hFF03;
        #1 chk("below_hit", hit, 1'b0);

        tick(37);
        reset = 1'b0;
        rd(16'hFF04, v); chk("arst_div", v, 8'h00);
        rd(16'hFF05, v); chk("arst_tima", v, 8'h00);
        rd(16'hFF06, v); chk("arst_tma", v, 8'h00);
        rd(16'hFF07, v); chk("arst_tac", v, 8'hF8);
        chk("arst_int", timer_int, 1'b0);
        tick(1);
        reset = 1'b1;
        tick(300);
        rd(16'hFF04, v); chk("restart_div", v, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gb_timer.md
# gb_timer

Memory-mapped DMG timer/divider that responds to CPU bus accesses at 0xFF04–0xFF07 (DIV, TIMA, TMA, TAC). It is the responder side of the CPU's address/data/wren bus and sits beside `memory` in the address decode. It supplies read data back to the CPU data mux and drives the `timer_int` request line into the interrupt flag logic. It runs in the CPU `clock` domain; one `clock` is one T-cycle.

## Interface
- `BASE_ADDR`, 16'hFF04: address of DIV; TIMA, TMA and TAC follow at +1, +2, +3.
- `clock`  in  1  CPU clock; all state is updated on its rising edge.
- `reset`  in  1  asynchronous, active-low; asserting it clears all state.
- `cpu_addr`  in  16  CPU bus address.
- `cpu_wren`  in  1  CPU write strobe; each cycle it is high is one write.
- `cpu_data_in`  in  8  write data from the CPU.
- `hit`  out  1  combinational; high when `cpu_addr` is in BASE_ADDR..BASE_ADDR+3.
- `data_out`  out  8  combinational read data; 8'hFF when `hit` is low.
- `timer_int`  out  1  registered; one-cycle pulse that requests the timer interrupt.

## Operation
- Internal state:
  - `div_cnt[15:0]`: increments every clock and wraps at 0xFFFF.
  - `tima`, `tma`: 8 bits each.
  - `tac`: 3 bits.
  - `reload_pending`: 1 bit.
- Reads:
  - DIV returns `div_cnt[15:8]`.
  - TIMA returns `tima`; TMA returns `tma`.
  - TAC returns `{5'b11111, tac}`.
- Tap select from `tac[1:0]`: 00 selects `div_cnt[9]`, 01 selects `[3]`, 10 selects `[5]`, 11 selects `[7]`.
- `tap = tac[2] & div_cnt[sel]`. A 1→0 transition of `tap` between consecutive cycles increments `tima`.
- Writes:
  - DIV: any data clears `div_cnt` to 0.
  - TAC: stores `cpu_data_in[2:0]`.
  - Both can cause a falling edge of `tap` that increments TIMA. This is the required DMG behaviour.
- TIMA overflow (increment from 0xFF):
  - Overflow cycle: `tima` becomes 0x00 and `reload_pending` is set.
  - Next cycle: `tima <= tma` (using TMA's value in that cycle, including a same-cycle write), `timer_int` pulses, and `reload_pending` clears.
- Writes to TIMA:
  - A TIMA write in the pending cycle cancels the reload and the interrupt; the written value wins.
  - A TIMA write in the same cycle as an increment: the write wins and there is no increment.
  - A TIMA write in the reload cycle is ignored; TMA is loaded.
- Writes outside BASE_ADDR..BASE_ADDR+3 are ignored.

## Timing
- Reset values: `div_cnt` 0, `tima` 0, `tma` 0, `tac` 0 (reads 8'hF8), `reload_pending` 0, `timer_int` 0.
- Write latency: a register written at edge N reads the new value after edge N.
- With TAC=0x05, TIMA increments every 16 clocks. The other tap rates are 1024, 64 and 256 clocks.
- Overflow to interrupt: `timer_int` is high exactly one cycle, on the cycle after TIMA reads 0x00.
- Release of reset mid-count: counting restarts from zero on the first edge after deassertion.

## Structure
- Shared package `gb_io_pkg`:
  - address constants `ADDR_DIV`, `ADDR_TIMA`, `ADDR_TMA`, `ADDR_TAC`;
  - enum `tac_sel_t` (`TAC_1024`, `TAC_16`, `TAC_64`, `TAC_256`);
  - constant `TAC_UNUSED_BITS = 5'b11111`.
- Single module with no sub-module. It holds one `always_ff` for state and one `always_comb` for the tap, next-TIMA and read mux.
- The previous `tap` value is held in a 1-bit register for edge detection.

## Test plan
- Release reset, then hold for 512 clocks → DIV reads 0x02, TIMA 0x00, TAC 0xF8, `timer_int` never asserted.
- Write TAC=0x05 and TMA=0x10 → TIMA increments by 1 every 16 clocks. After 256×16 clocks it overflows: one cycle at 0x00, then 0x10, with a single-cycle `timer_int` pulse.
- Set TIMA=0xFF, TAC=0x05, and write TIMA=0x40 in the cycle where TIMA reads 0x00 → TIMA=0x40 and no `timer_int`.
- With TAC=0x05 and `div_cnt[3]=1`, write DIV → DIV reads 0x00 and TIMA increments by 1 immediately (glitch edge).
- With TAC=0x05 and `div_cnt[3]=1`, write TAC=0x01 → TIMA increments by 1. Afterwards, 1000 clocks produce no further increments.
- Write to 0xFF08 with data 0xAA → `hit`=0, `data_out`=0xFF, no register changes. Assert `reset` mid-count → all reads return reset values asynchronously.
